// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the RV32M multiply/divide unit.
//   funct3 encodings for the eight M-extension ops, the FSM state
//   encoding, and small helpers that decode operand signedness.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Divide-family ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // Operand B is treated as signed for MULH, DIV and REM.
    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//   One operation at a time, fixed 34-edge latency from accepted start to
//   the end of the done pulse: 32 CALC iterations on operand magnitudes,
//   one FIXUP cycle for sign correction / special cases, one DONE cycle.
//
// Handshake: start is a request that is accepted only when busy=0 (IDLE or
//   DONE); a start seen while busy=1 is dropped. done is a one-cycle pulse
//   that marks result valid; result holds until the next accepted start
//   completes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   operation request
//   funct3     in   RV32M op select (see muldiv_pkg)
//   op_a       in   operand A
//   op_b       in   operand B
//   busy       out  high in CALC and FIXUP
//   done       out  high for the single DONE cycle
//   result     out  registered result
//   state_dbg  out  current FSM state, for observation only
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output state_e      state_dbg
);

    state_e      state;
    logic [4:0]  count;
    logic [2:0]  f_q;
    logic [31:0] a_q;       // raw op_a, needed for the REM-by-zero return
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_a;
    logic        neg_b;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [63:0] acc;

    assign state_dbg = state;

    // Operand magnitudes at the moment of acceptance.
    logic        start_neg_a;
    logic        start_neg_b;
    logic [31:0] start_mag_a;
    logic [31:0] start_mag_b;

    always_comb begin
        start_neg_a = signed_a(funct3) && op_a[31];
        start_neg_b = signed_b(funct3) && op_b[31];
        start_mag_a = start_neg_a ? (~op_a + 32'd1) : op_a;
        start_mag_b = start_neg_b ? (~op_b + 32'd1) : op_b;
    end

    // One iteration of shift-add multiply or restoring divide.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        // True difference is below 2^32 whenever div_ge holds.
        div_diff  = div_shift[31:0] - mag_b;
        if (is_div(f_q)) begin
            acc_next = div_ge ? {div_diff, acc[30:0], 1'b1}
                              : {div_shift[31:0], acc[30:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

    // Sign correction and special cases applied in FIXUP.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] fix_result;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
        quo_fix  = (neg_a ^ neg_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
        div_zero = (mag_b == 32'd0);
        // Signed 0x80000000 / -1: only reachable with both sign flags set.
        div_ovf  = neg_a && neg_b && (a_q == 32'h8000_0000) && (mag_b == 32'd1);
        fix_result = 32'd0;
        unique case (f_q)
            F3_MUL:                       fix_result = prod_fix[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[63:32];
            F3_DIV, F3_DIVU: begin
                if (div_zero)     fix_result = 32'hFFFF_FFFF;
                else if (div_ovf) fix_result = 32'h8000_0000;
                else              fix_result = quo_fix;
            end
            F3_REM, F3_REMU: begin
                if (div_zero)     fix_result = a_q;
                else if (div_ovf) fix_result = 32'd0;
                else              fix_result = rem_fix;
            end
            default:              fix_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            count  <= 5'd0;
            f_q    <= 3'd0;
            a_q    <= 32'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc    <= 64'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_CALC;
                        busy  <= 1'b1;
                        count <= 5'd0;
                        f_q   <= funct3;
                        a_q   <= op_a;
                        mag_a <= start_mag_a;
                        mag_b <= start_mag_b;
                        neg_a <= start_neg_a;
                        neg_b <= start_neg_b;
                        acc   <= {32'd0, is_div(funct3) ? start_mag_a : start_mag_b};
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;   // wraps 31 -> 0 on the exit edge
                    if (count == 5'd31) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result <= fix_result;
                    state  <= ST_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit with hand-computed
//   expected results held in an expected queue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    state_e      state_dbg;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op and follows it to done. Inputs are sampled on posedge
    // and driven/observed on negedge. With b2b set the start is raised at
    // the current negedge (used right after a done is seen).
    // inject_at >= 0 pulses start with junk operands at that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input bit b2b, input int inject_at);
        int lat;
        int busy_cnt;
        logic [31:0] exp_v;
        if (!b2b) @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(e);
        @(negedge clk);
        // Scramble inputs immediately; only latched values may matter.
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (lat == inject_at) begin
                start  = 1'b1;
                funct3 = 3'($urandom_range(0, 7));
                op_a   = $urandom;
                op_b   = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        exp_v = exp_q.pop_front();
        check({tag, " latency"}, lat, 32'd33);
        check({tag, " busy_cycles"}, busy_cnt, 32'd33);
        check({tag, " result"}, result, exp_v);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        string       tag;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int done_seen;

        vecs[0]  = '{"mul_7x6",        F3_MUL,    32'd7,          32'd6,          32'h0000_002A};
        vecs[1]  = '{"mulh_m1xm1",     F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[2]  = '{"mulhu_m1xm1",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[3]  = '{"mulhsu_m1x2",    F3_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF};
        vecs[4]  = '{"div_m7_2",       F3_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{"rem_m7_2",       F3_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{"divu_100_7",     F3_DIVU,   32'd100,        32'd7,          32'd14};
        vecs[7]  = '{"remu_100_7",     F3_REMU,   32'd100,        32'd7,          32'd2};
        vecs[8]  = '{"div_5_0",        F3_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{"rem_x_0",        F3_REM,    32'h8000_0005,  32'd0,          32'h8000_0005};
        vecs[10] = '{"div_ovf",        F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[11] = '{"rem_ovf",        F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[12] = '{"mul_m1xm1_lo",   F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[13] = '{"mulh_min_min",   F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[14] = '{"mulhsu_min_max", F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[15] = '{"mulh_m2x3",      F3_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        vecs[16] = '{"div_7_m2",       F3_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[17] = '{"rem_m8_m3",      F3_REM,    32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE};
        vecs[18] = '{"divu_max_0",     F3_DIVU,   32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
        vecs[19] = '{"remu_max_0",     F3_REMU,   32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};

        n_checks = 0;
        n_fail   = 0;

        // Reset with start held high: reset must win.
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = F3_MUL;
        op_a   = 32'd9;
        op_b   = 32'd9;
        repeat (3) @(negedge clk);
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state",  {30'd0, state_dbg}, {30'd0, ST_IDLE});
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle after reset busy", {31'd0, busy}, 32'd0);

        // Directed vectors, each followed by a done-low check.
        foreach (vecs[i]) begin
            run_op(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0, -1);
            @(negedge clk);
            check({vecs[i].tag, " done_low_after"}, {31'd0, done}, 32'd0);
            check({vecs[i].tag, " idle_after"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
        end

        // Start plus new operands while busy must be ignored.
        run_op("mul_3x5_ignore", F3_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 10);

        // Back-to-back: second start in the done cycle.
        run_op("b2b_first",  F3_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, -1);
        run_op("b2b_second", F3_MUL,  32'd12345, 32'd1000, 32'd12345000, 1'b1, -1);
        @(negedge clk);
        check("b2b done_low_after", {31'd0, done}, 32'd0);

        // Reset abort in the middle of a divide.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F3_DIV;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",   {31'd0, busy}, 32'd0);
        check("abort done",   {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort state",  {30'd0, state_dbg}, {30'd0, ST_IDLE});
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort no_done_pulse", done_seen, 32'd0);

        // Recovery after abort.
        run_op("after_abort_rem", F3_REM, 32'd1000, 32'd7, 32'd6, 1'b0, -1);

        check("exp_q drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
